// File: rtl/l2tlb_req_arb_pkg.sv
// Shared types and defaults for the L2 TLB request arbiter.
// Payload structs for the TLB-to-L2 request and L2-to-TLB ack channels, plus the source-ID encoding.
package l2tlb_req_arb_pkg;

    localparam int unsigned MAX_OUT_DEF = 4;

    localparam int unsigned ASID_W = 8;
    localparam int unsigned VPN_W  = 27;
    localparam int unsigned PPN_W  = 28;
    localparam int unsigned PERM_W = 4;

    typedef struct packed {
        logic [ASID_W-1:0] asid;
        logic [VPN_W-1:0]  vpn;
    } I_dctlbtol2tlb_req_type;

    typedef struct packed {
        logic [PPN_W-1:0]  ppn;
        logic [PERM_W-1:0] perm;
        logic              fault;
    } I_l2tlbtodctlb_ack_type;

    typedef enum logic {
        SRC_D = 1'b0,
        SRC_I = 1'b1
    } src_id_e;

endpackage

// File: rtl/l2tlb_src_fifo.sv
// Source-ID FIFO for outstanding L2 TLB misses; 1-bit entries, simultaneous push/pop (also when full).
// Its occupancy counter doubles as the arbiter's outstanding-request count.
module l2tlb_src_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_c,
    output logic full_c,
    output logic empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (cnt == CNT_W'(DEPTH));
    assign empty_c = (cnt == '0);
    assign head_c  = mem[rd_ptr];

    // A push at full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/l2tlb_req_arb.sv
// Arbitrates DCTLB/ICTLB misses onto one registered L2 TLB request stage and steers in-order acks back.
// Define TLB_ARB_FIXED_PRIO_EN to give DCTLB fixed priority instead of round-robin.
module l2tlb_req_arb
    import l2tlb_req_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEF,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   dctlbtol2tlb_req_valid,
    output logic                   dctlbtol2tlb_req_retry,
    input  I_dctlbtol2tlb_req_type dctlbtol2tlb_req,

    input  logic                   ictlbtol2tlb_req_valid,
    output logic                   ictlbtol2tlb_req_retry,
    input  I_dctlbtol2tlb_req_type ictlbtol2tlb_req,

    output logic                   arbtol2tlb_req_valid,
    input  logic                   arbtol2tlb_req_retry,
    output I_dctlbtol2tlb_req_type arbtol2tlb_req,

    input  logic                   l2tlbtoarb_ack_valid,
    output logic                   l2tlbtoarb_ack_retry,
    input  I_l2tlbtodctlb_ack_type l2tlbtoarb_ack,

    output logic                   l2tlbtodctlb_ack_valid,
    input  logic                   l2tlbtodctlb_ack_retry,
    output I_l2tlbtodctlb_ack_type l2tlbtodctlb_ack,

    output logic                   l2tlbtoictlb_ack_valid,
    input  logic                   l2tlbtoictlb_ack_retry,
    output I_l2tlbtodctlb_ack_type l2tlbtoictlb_ack,

    output logic                   arb_err
);

    logic d_v;
    logic i_v;
    logic fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic head_is_i;
    logic sel_ack_retry;
    logic ack_xfer;
    logic ack_orphan;
    logic oreg_free;
    logic oreg_xfer;
    logic can_accept;
    logic win_i;
    logic grant;

    assign d_v = dctlbtol2tlb_req_valid;
    assign i_v = ictlbtol2tlb_req_valid;

    // Ack steering: the FIFO head names the requester that owns the returning ack.
    assign head_is_i     = (fifo_head == SRC_I);
    assign sel_ack_retry = head_is_i ? l2tlbtoictlb_ack_retry : l2tlbtodctlb_ack_retry;
    assign ack_xfer      = l2tlbtoarb_ack_valid && !fifo_empty && !sel_ack_retry;
    assign ack_orphan    = l2tlbtoarb_ack_valid && fifo_empty && !reset;

    assign l2tlbtoarb_ack_retry   = fifo_empty ? 1'b0 : sel_ack_retry;
    assign l2tlbtodctlb_ack_valid = !reset && l2tlbtoarb_ack_valid && !fifo_empty && !head_is_i;
    assign l2tlbtoictlb_ack_valid = !reset && l2tlbtoarb_ack_valid && !fifo_empty && head_is_i;
    assign l2tlbtodctlb_ack       = l2tlbtoarb_ack;
    assign l2tlbtoictlb_ack       = l2tlbtoarb_ack;

    assign oreg_xfer  = arbtol2tlb_req_valid && !arbtol2tlb_req_retry;
    assign oreg_free  = !arbtol2tlb_req_valid || !arbtol2tlb_req_retry;
    assign can_accept = !reset && oreg_free && (!fifo_full || ack_xfer);

`ifdef TLB_ARB_FIXED_PRIO_EN
    assign win_i = i_v && !d_v;
`else
    src_id_e rr_last;

    // Both valid: the requester not granted most recently wins.
    assign win_i = i_v && (!d_v || (rr_last == SRC_D));

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= SRC_I;
        end else if (grant) begin
            rr_last <= win_i ? SRC_I : SRC_D;
        end
    end
`endif

    assign grant = can_accept && (d_v || i_v);

    // The losing requester always sees retry; the winner or an idle one sees !can_accept.
    assign dctlbtol2tlb_req_retry = !can_accept || (d_v && win_i);
    assign ictlbtol2tlb_req_retry = !can_accept || (i_v && d_v && !win_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            arbtol2tlb_req_valid <= 1'b0;
            arbtol2tlb_req       <= '0;
            arb_err              <= 1'b0;
        end else begin
            if (grant) begin
                arbtol2tlb_req_valid <= 1'b1;
                arbtol2tlb_req       <= win_i ? ictlbtol2tlb_req : dctlbtol2tlb_req;
            end else if (oreg_xfer) begin
                arbtol2tlb_req_valid <= 1'b0;
            end
            if (ack_orphan) begin
                arb_err <= 1'b1;
            end
        end
    end

    l2tlb_src_fifo #(
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_src_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (grant),
        .push_id (win_i),
        .pop     (ack_xfer),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

endmodule

// File: tb/tb_l2tlb_req_arb.sv
// Randomized self-checking bench for l2tlb_req_arb with a queue-based reference model.
// Honours TLB_ARB_FIXED_PRIO_EN when the same macro is defined for the build.
module tb_l2tlb_req_arb;
    import l2tlb_req_arb_pkg::*;

    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic d_v = 1'b0, i_v = 1'b0, l2_retry = 1'b0, ack_v = 1'b0;
    logic dack_retry = 1'b0, iack_retry = 1'b0;
    I_dctlbtol2tlb_req_type d_pl = '0, i_pl = '0;
    I_l2tlbtodctlb_ack_type ack_pl = '0;

    logic d_retry, i_retry, req_valid, ack_retry, dack_valid, iack_valid, arb_err;
    I_dctlbtol2tlb_req_type req_pl;
    I_l2tlbtodctlb_ack_type dack_pl, iack_pl;

    always #5 clk = ~clk;

    l2tlb_req_arb #(.MAX_OUT(MAX_OUT)) u_dut (
        .clk                    (clk),
        .reset                  (reset),
        .dctlbtol2tlb_req_valid (d_v),
        .dctlbtol2tlb_req_retry (d_retry),
        .dctlbtol2tlb_req       (d_pl),
        .ictlbtol2tlb_req_valid (i_v),
        .ictlbtol2tlb_req_retry (i_retry),
        .ictlbtol2tlb_req       (i_pl),
        .arbtol2tlb_req_valid   (req_valid),
        .arbtol2tlb_req_retry   (l2_retry),
        .arbtol2tlb_req         (req_pl),
        .l2tlbtoarb_ack_valid   (ack_v),
        .l2tlbtoarb_ack_retry   (ack_retry),
        .l2tlbtoarb_ack         (ack_pl),
        .l2tlbtodctlb_ack_valid (dack_valid),
        .l2tlbtodctlb_ack_retry (dack_retry),
        .l2tlbtodctlb_ack       (dack_pl),
        .l2tlbtoictlb_ack_valid (iack_valid),
        .l2tlbtoictlb_ack_retry (iack_retry),
        .l2tlbtoictlb_ack       (iack_pl),
        .arb_err                (arb_err)
    );

    // Reference model state: outstanding source IDs, the output stage, and requests seen by the L2.
    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    I_dctlbtol2tlb_req_type l2_q[$];
    logic [ASID_W-1:0] obs_q[$];
    bit oreg_v = 0;
    I_dctlbtol2tlb_req_type oreg_pl = '0;
    bit last_i = 1;
    bit err = 0;
    bit d_hold = 0, i_hold = 0, ack_hold = 0;
    bit auto_l2 = 0;
    bit rand_req = 0;
    int ack_prob = 60;
    int rtry_prob = 30;
    int dsr_prob = 25;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic I_l2tlbtodctlb_ack_type mk_ack(input I_dctlbtol2tlb_req_type r);
        I_l2tlbtodctlb_ack_type a;
        a.ppn   = PPN_W'(r.vpn) + PPN_W'(28'h100);
        a.perm  = r.asid[PERM_W-1:0];
        a.fault = r.vpn[0];
        return a;
    endfunction

    task automatic drive_req();
        if (!d_hold) begin
            d_v = ($urandom_range(0, 99) < 55);
            d_pl.asid = ASID_W'($urandom());
            d_pl.vpn  = VPN_W'($urandom());
        end
        if (!i_hold) begin
            i_v = ($urandom_range(0, 99) < 55);
            i_pl.asid = ASID_W'($urandom());
            i_pl.vpn  = VPN_W'($urandom());
        end
        l2_retry   = ($urandom_range(0, 99) < rtry_prob);
        dack_retry = ($urandom_range(0, 99) < dsr_prob);
        iack_retry = ($urandom_range(0, 99) < dsr_prob);
    endtask

    task automatic drive_l2();
        if (!ack_hold) begin
            if (l2_q.size() > 0 && $urandom_range(0, 99) < ack_prob) begin
                ack_v  = 1'b1;
                ack_pl = mk_ack(l2_q[0]);
            end else begin
                ack_v  = 1'b0;
                ack_pl = '0;
            end
        end
    endtask

    // One clock: settle inputs, compare every output against the model, then advance the model.
    task automatic cycle();
        bit empty, head, sel_r, ack_x, can, win_i, grant, ex_dr, ex_ir;
        if (rand_req) drive_req();
        if (auto_l2) drive_l2();
        #1;
        empty = (exp_q.size() == 0);
        head  = empty ? 1'b0 : exp_q[0];
        sel_r = head ? iack_retry : dack_retry;
        ack_x = !reset && ack_v && !empty && !sel_r;
        can   = !reset && (!oreg_v || !l2_retry) && (exp_q.size() < MAX_OUT || ack_x);
`ifdef TLB_ARB_FIXED_PRIO_EN
        win_i = i_v && !d_v;
`else
        win_i = i_v && (!d_v || !last_i);
`endif
        grant = can && (d_v || i_v);
        ex_dr = reset || !can || (d_v && win_i);
        ex_ir = reset || !can || (i_v && d_v && !win_i);

        chk("req_valid", 64'(req_valid), 64'(oreg_v));
        if (oreg_v) chk("req_payload", 64'(req_pl), 64'(oreg_pl));
        chk("d_req_retry", 64'(d_retry), 64'(ex_dr));
        chk("i_req_retry", 64'(i_retry), 64'(ex_ir));
        if (!reset) chk("ack_retry", 64'(ack_retry), 64'(empty ? 1'b0 : sel_r));
        chk("dack_valid", 64'(dack_valid), 64'(!reset && ack_v && !empty && !head));
        chk("iack_valid", 64'(iack_valid), 64'(!reset && ack_v && !empty && head));
        if (ack_v) begin
            chk("dack_payload", 64'(dack_pl), 64'(ack_pl));
            chk("iack_payload", 64'(iack_pl), 64'(ack_pl));
        end
        chk("arb_err", 64'(arb_err), 64'(err));
        if (req_valid && !l2_retry) obs_q.push_back(req_pl.asid);

        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            l2_q.delete();
            oreg_v = 0;
            last_i = 1;
            err = 0;
            d_hold = 0;
            i_hold = 0;
            ack_hold = 0;
            ack_v = 1'b0;
        end else begin
            if (oreg_v && !l2_retry) begin
                l2_q.push_back(oreg_pl);
                oreg_v = 0;
            end
            if (grant) begin
                oreg_v  = 1;
                oreg_pl = win_i ? i_pl : d_pl;
                exp_q.push_back(win_i);
                last_i  = win_i;
            end
            if (ack_x) begin
                void'(exp_q.pop_front());
                if (l2_q.size() > 0) void'(l2_q.pop_front());
            end
            if (ack_v && empty) err = 1;
            d_hold   = d_v && ex_dr;
            i_hold   = i_v && ex_ir;
            ack_hold = ack_v && !empty && !ack_x;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        d_v = 0; i_v = 0; ack_v = 0; l2_retry = 0; dack_retry = 0; iack_retry = 0;
        auto_l2 = 0; rand_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    initial begin
        logic [ASID_W-1:0] pat [6];
        bit route [4];
        I_dctlbtol2tlb_req_type pa, pb, pc;

        @(posedge clk);
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_arb_err", 64'(arb_err), 64'(0));

        // Single D request: visible one cycle later, ack routed to DCTLB.
        d_v = 1; d_pl.asid = 8'h0D; d_pl.vpn = 27'h1234;
        cycle();
        d_v = 0;
        #1;
        chk("t1_valid_n1", 64'(req_valid), 64'(1));
        chk("t1_payload", 64'(req_pl), 64'({8'h0D, 27'h1234}));
        cycle();
        ack_v = 1; ack_pl = mk_ack(d_pl); dack_retry = 0;
        #1;
        chk("t1_dack", 64'(dack_valid), 64'(1));
        chk("t1_iack", 64'(iack_valid), 64'(0));
        cycle();
        ack_v = 0;
        chk("t1_count", 64'(exp_q.size()), 64'(0));

        // Both requesters always valid, immediate acks.
        do_reset();
        obs_q.delete();
        d_v = 1; d_pl.asid = 8'h0D; d_pl.vpn = 27'h0AAA;
        i_v = 1; i_pl.asid = 8'h01; i_pl.vpn = 27'h0BBB;
        auto_l2 = 1; ack_prob = 100;
        for (int k = 0; k < 10; k++) cycle();
        idle_inputs();
`ifdef TLB_ARB_FIXED_PRIO_EN
        pat = '{8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h0D};
`else
        pat = '{8'h0D, 8'h01, 8'h0D, 8'h01, 8'h0D, 8'h01};
`endif
        for (int k = 0; k < 6; k++)
            chk("t2_grant_order", 64'(obs_q.size() > k ? obs_q[k] : 8'hFF), 64'(pat[k]));

        // Fill to MAX_OUT, then accept a fifth request alongside an ack.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d_v = 1; d_pl.asid = 8'h0D; d_pl.vpn = VPN_W'(k + 1);
            cycle();
        end
        #1;
        chk("t3_full_dretry", 64'(d_retry), 64'(1));
        chk("t3_full_iretry", 64'(i_retry), 64'(1));
        ack_v = 1; ack_pl = mk_ack(l2_q[0]); d_pl.vpn = 27'h5;
        #1;
        chk("t3_ack_accept", 64'(d_retry), 64'(0));
        cycle();
        ack_v = 0; d_v = 0;
        chk("t3_count", 64'(exp_q.size()), 64'(4));
        #1;
        chk("t3_full_again", 64'(d_retry), 64'(1));

        // Order D,I,I,D and in-order acks with a stalled ICTLB.
        do_reset();
        route = '{0, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            d_v = !route[k]; i_v = route[k];
            d_pl.vpn = VPN_W'(16 + k); i_pl.vpn = VPN_W'(32 + k);
            cycle();
        end
        d_v = 0; i_v = 0;
        cycle();
        for (int k = 0; k < 4; k++) begin
            ack_v = 1; ack_pl = mk_ack(l2_q[0]);
            if (k == 1) begin
                iack_retry = 1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("t4_stall_retry", 64'(ack_retry), 64'(1));
                    chk("t4_stall_head", 64'(iack_valid), 64'(1));
                    cycle();
                end
                iack_retry = 0;
            end
            #1;
            chk("t4_route_d", 64'(dack_valid), 64'(!route[k]));
            chk("t4_route_i", 64'(iack_valid), 64'(route[k]));
            cycle();
        end
        ack_v = 0;

        // L2 back-pressure holds the output stage.
        do_reset();
        pa = '{asid: 8'hA0, vpn: 27'h00A};
        pb = '{asid: 8'hB0, vpn: 27'h00B};
        pc = '{asid: 8'hC0, vpn: 27'h00C};
        d_v = 1; d_pl = pa;
        cycle();
        d_pl = pb; i_v = 1; i_pl = pc; l2_retry = 1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t5_hold_valid", 64'(req_valid), 64'(1));
            chk("t5_hold_payload", 64'(req_pl), 64'(pa));
            chk("t5_hold_dretry", 64'(d_retry), 64'(1));
            chk("t5_hold_iretry", 64'(i_retry), 64'(1));
            cycle();
        end
        l2_retry = 0;
        cycle();
        d_v = 0; i_v = 0;
        #1;
        chk("t5_next_valid", 64'(req_valid), 64'(1));
`ifdef TLB_ARB_FIXED_PRIO_EN
        chk("t5_next_payload", 64'(req_pl), 64'(pb));
`else
        chk("t5_next_payload", 64'(req_pl), 64'(pc));
`endif
        cycle();

        // Orphan ack sets the sticky error; reset mid-traffic clears everything.
        do_reset();
        ack_v = 1; ack_pl = '{ppn: 28'hDEAD, perm: 4'h3, fault: 1'b0};
        #1;
        chk("t6_orphan_dack", 64'(dack_valid), 64'(0));
        chk("t6_orphan_iack", 64'(iack_valid), 64'(0));
        chk("t6_orphan_retry", 64'(ack_retry), 64'(0));
        cycle();
        ack_v = 0;
        for (int s = 0; s < 3; s++) cycle();
        #1;
        chk("t6_err_sticky", 64'(arb_err), 64'(1));
        rand_req = 1; auto_l2 = 1; ack_prob = 50;
        for (int s = 0; s < 20; s++) cycle();
        rand_req = 0; auto_l2 = 0;
        reset = 1;
        cycle();
        reset = 0;
        idle_inputs();
        #1;
        chk("t6_rst_valid", 64'(req_valid), 64'(0));
        chk("t6_rst_dack", 64'(dack_valid), 64'(0));
        chk("t6_rst_iack", 64'(iack_valid), 64'(0));
        chk("t6_rst_err", 64'(arb_err), 64'(0));
        chk("t6_rst_count", 64'(exp_q.size()), 64'(0));
        cycle();

        // Long randomized run against the model.
        do_reset();
        rand_req = 1; auto_l2 = 1; ack_prob = 60;
        for (int s = 0; s < 3000; s++) begin
            if (s == 1500) begin
                ack_prob = 20; rtry_prob = 10;
            end
            cycle();
        end
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2tlb_req_arb.md
Name: l2tlb_req_arb

Overview:
Shares the single L2 TLB request/ack channel between the DCTLB and ICTLB miss paths. It round-robin arbitrates the two requesters into one registered request stage toward the L2 TLB. A source-ID FIFO tracks outstanding misses. Returning acks, which the L2 TLB delivers in request order, are steered back to the requester that issued them.

Parameters:
MAX_OUT, 4, max outstanding L2 TLB requests (in output register plus issued-unacked); power of 2, >=2
CNT_W, $clog2(MAX_OUT+1), width of outstanding counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dctlbtol2tlb_req_valid  in  1  DCTLB miss request valid
dctlbtol2tlb_req_retry  out  1  back-pressure to DCTLB
dctlbtol2tlb_req  in  I_dctlbtol2tlb_req_type  DCTLB request payload
ictlbtol2tlb_req_valid  in  1  ICTLB miss request valid
ictlbtol2tlb_req_retry  out  1  back-pressure to ICTLB
ictlbtol2tlb_req  in  I_dctlbtol2tlb_req_type  ICTLB request payload (same type)
arbtol2tlb_req_valid  out  1  merged request valid
arbtol2tlb_req_retry  in  1  L2 TLB back-pressure
arbtol2tlb_req  out  I_dctlbtol2tlb_req_type  merged request payload
l2tlbtoarb_ack_valid  in  1  L2 TLB ack valid
l2tlbtoarb_ack_retry  out  1  back-pressure to L2 TLB
l2tlbtoarb_ack  in  I_l2tlbtodctlb_ack_type  ack payload
l2tlbtodctlb_ack_valid / _retry / l2tlbtodctlb_ack  out/in/out  1/1/type  ack to DCTLB
l2tlbtoictlb_ack_valid / _retry / l2tlbtoictlb_ack  out/in/out  1/1/type  ack to ICTLB
arb_err  out  1  sticky protocol error (ack with no outstanding entry)

Behaviour:
- Handshake on every channel: a transfer occurs when valid && !retry. The sender holds valid and payload stable while retry is high.
- Reset values:
  - arbtol2tlb_req_valid=0, both ack valids=0, arb_err=0.
  - Both req retries=1 while reset is high.
  - FIFO empty, count=0, RR pointer = DCTLB-first.
- Output register (one entry, "oreg"):
  - A request accepted in cycle N appears on arbtol2tlb_req_valid in cycle N+1.
  - oreg is "free" when it is empty, or when it is full and transferring this cycle.
- Acceptance:
  - can_accept = oreg free && (count < MAX_OUT || ack transfer this cycle).
  - Retries: winner's retry = !can_accept; loser's retry = 1; an idle requester's retry = !can_accept.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted most recently wins.
  - The RR pointer updates only on an actual grant transfer.
- Source FIFO (depth MAX_OUT, 1-bit entries, 0=D, 1=I):
  - Push the winner ID on grant.
  - Pop on an upstream ack transfer.
  - Push and pop in the same cycle are legal, including at full.
- count: +1 on grant, -1 on ack transfer; both in the same cycle leaves it unchanged. It never exceeds MAX_OUT.
- Ack steering (combinational, zero latency):
  - Head=D: l2tlbtodctlb_ack_valid = l2tlbtoarb_ack_valid; l2tlbtoarb_ack_retry = l2tlbtodctlb_ack_retry.
  - Head=I: the same, via the ICTLB ack channel.
  - The payload is broadcast to both destinations; only the selected valid is asserted.
- Ack with FIFO empty: the ack is consumed (retry=0), no downstream valid is driven, and arb_err is set until reset.
- Reset mid-operation: in-flight state is discarded and oreg is cleared. The L2 TLB is reset on the same reset, so no stale acks arrive.

Optional Feature:
TLB_ARB_FIXED_PRIO_EN
- Defined: DCTLB always wins when both requesters are valid; the RR pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical.

Decomposition:
- Shared package: I_dctlbtol2tlb_req_type, I_l2tlbtodctlb_ack_type, a source-ID enum (SRC_D=0, SRC_I=1), and the MAX_OUT default.
- One natural sub-module: l2tlb_src_fifo, a parameterized 1-bit-wide FIFO with simultaneous push/pop, full and empty flags.

Test Plan:
1. Single D request, L2 retry=0 -> arbtol2tlb_req_valid high exactly 1 cycle later with D payload. Ack returned -> l2tlbtodctlb_ack_valid=1, ICTLB ack valid=0, count back to 0.
2. D and I both valid continuously, retry=0, acks returned immediately -> grants alternate D,I,D,I. With TLB_ARB_FIXED_PRIO_EN, all grants go to D.
3. Issue 4 requests with no acks (MAX_OUT=4) -> both req retries=1. An ack in the same cycle as a 5th request -> that request is accepted and count stays 4.
4. Order D,I,I,D, then 4 in-order acks -> acks routed D,I,I,D. ICTLB ack retry held high for 3 cycles -> l2tlbtoarb_ack_retry high for those 3 cycles, and FIFO head unchanged.
5. arbtol2tlb_req_retry=1 for 5 cycles with oreg full -> payload stable and requesters see retry=1. After retry drops, the next request issues 1 cycle later.
6. Ack injected with count=0 -> no downstream ack valid, arb_err=1 until reset. Reset asserted mid-traffic -> all valids 0 the next cycle and count=0.
